// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with pending-write scoreboard and post-reset clear sweep
//
// Purpose: integer register file between decode and writeback. The array
// itself has no reset; after reset a sequencer writes one register per cycle
// (x2 <- SP_INIT, x8 <- FP_INIT, all others 0). After that it raises ready.
// A per-register pending bit tracks in-flight destinations for RAW stalls.
//
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read
// forwarding on both read ports, including the pending outputs.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous reset, active low
//   ready      out  clear sweep complete
//   rs1, rs2   in   read addresses
//   rrs1, rrs2 out  combinational read data (0 for x0 and while not ready)
//   wr_req     in   writeback strobe
//   rd         in   writeback address
//   wr_data    in   writeback data
//   issue_req  in   instruction with a destination issues this cycle
//   issue_rd   in   destination of the issuing instruction
//   pend1/2    out  rs1/rs2 has an outstanding write
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'hff00),
  parameter logic [XLEN-1:0] FP_INIT = XLEN'(32'hff00),
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rrs1,
  output logic [XLEN-1:0] rrs2,
  input  logic            wr_req,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_req,
  input  logic [AW-1:0]   issue_rd,
  output logic            pend1,
  output logic            pend2
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   cnt;

  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;

  logic [XLEN-1:0] mem [NREG];
  logic [XLEN-1:0] arr1, arr2;

  logic [NREG-1:0] pend, pend_set, pend_clr;

  // State register and sweep counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) cnt <= cnt + AW'(1);
    end
  end

  // Next state: RUN is terminal, only reset leaves it
  always_comb begin
    state_next = state;
    if (state == CLEAR && cnt == AW'(NREG - 1)) state_next = RUN;
  end

  // Array write port: the sweep owns it in CLEAR, writeback owns it in RUN
  always_comb begin
    we    = 1'b0;
    waddr = cnt;
    wdata = '0;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt;
        if (cnt == AW'(2))      wdata = SP_INIT;
        else if (cnt == AW'(8)) wdata = FP_INIT;
      end
      RUN: begin
        we    = wr_req && (rd != '0);
        waddr = rd;
        wdata = wr_data;
      end
      default: ;
    endcase
  end

  // No reset on the array so it can map to distributed RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign arr1 = (rs1 == '0) ? '0 : mem[rs1];
  assign arr2 = (rs2 == '0) ? '0 : mem[rs2];

  // Scoreboard: set is applied after clear so a same-register collision
  // keeps the bit set (a new producer has issued). Bit 0 never sets.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (state == RUN) begin
      if (issue_req) pend_set[issue_rd] = 1'b1;
      if (wr_req)    pend_clr[rd]       = 1'b1;
    end
    pend_set[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend <= '0;
    else        pend <= (pend & ~pend_clr) | pend_set;
  end

  // Outputs: everything reads 0 until the sweep has finished
  always_comb begin
    ready = 1'b0;
    rrs1  = '0;
    rrs2  = '0;
    pend1 = 1'b0;
    pend2 = 1'b0;
    if (state == RUN) begin
      ready = 1'b1;
      rrs1  = arr1;
      rrs2  = arr2;
      pend1 = pend[rs1];
      pend2 = pend[rs2];
`ifdef REGFILE_BYPASS_EN
      // Forward the writeback; the pending bit drops this cycle unless a
      // new producer for the same register issues alongside it.
      if (wr_req && rd != '0 && rd == rs1) begin
        rrs1  = wr_data;
        pend1 = issue_req && (issue_rd == rs1);
      end
      if (wr_req && rd != '0 && rd == rs2) begin
        rrs2  = wr_data;
        pend2 = issue_req && (issue_rd == rs2);
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard testbench for regfile_sb with a behavioural reference model
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ready, wr_req, issue_req, pend1, pend2;
  logic [4:0]  rs1, rs2, rd, issue_rd;
  logic [31:0] rrs1, rrs2, wr_data;

  regfile_sb dut (
    .clk(clk), .reset(reset), .ready(ready),
    .rs1(rs1), .rs2(rs2), .rrs1(rrs1), .rrs2(rrs2),
    .wr_req(wr_req), .rd(rd), .wr_data(wr_data),
    .issue_req(issue_req), .issue_rd(issue_rd),
    .pend1(pend1), .pend2(pend2)
  );

  logic        reset_b, ready_b, wr_req_b, issue_req_b, pend1_b, pend2_b;
  logic [3:0]  rs1_b, rs2_b, rd_b, issue_rd_b;
  logic [63:0] rrs1_b, rrs2_b, wr_data_b;

  regfile_sb #(.XLEN(64), .NREG(16), .SP_INIT(64'h1_0000)) dut_b (
    .clk(clk), .reset(reset_b), .ready(ready_b),
    .rs1(rs1_b), .rs2(rs2_b), .rrs1(rrs1_b), .rrs2(rrs2_b),
    .wr_req(wr_req_b), .rd(rd_b), .wr_data(wr_data_b),
    .issue_req(issue_req_b), .issue_rd(issue_rd_b),
    .pend1(pend1_b), .pend2(pend2_b)
  );

  typedef struct packed {
    logic        r;
    logic [31:0] a;
    logic [31:0] b;
    logic        p1;
    logic        p2;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: register contents, pending set, sweep progress
  logic [31:0] m_x [32];
  bit   [31:0] m_pend;
  bit          m_ready;
  int          m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
  endtask

  // Apply the inputs that were present at this rising edge
  function automatic void commit();
    if (!reset) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      m_pend  = '0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 32) begin
        m_ready = 1'b1;
        foreach (m_x[i]) m_x[i] = (i == 2 || i == 8) ? 32'hff00 : 32'h0;
      end
    end else begin
      if (wr_req) begin
        m_pend[rd] = 1'b0;
        if (rd != 0) m_x[rd] = wr_data;
      end
      if (issue_req && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    end
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e = '0;
    if (reset && m_ready) begin
      e.r  = 1'b1;
      e.a  = (rs1 == 0) ? 32'h0 : m_x[rs1];
      e.b  = (rs2 == 0) ? 32'h0 : m_x[rs2];
      e.p1 = m_pend[rs1];
      e.p2 = m_pend[rs2];
`ifdef REGFILE_BYPASS_EN
      if (wr_req && rd != 0 && rd == rs1) begin
        e.a  = wr_data;
        e.p1 = issue_req && (issue_rd == rs1);
      end
      if (wr_req && rd != 0 && rd == rs2) begin
        e.b  = wr_data;
        e.p2 = issue_req && (issue_rd == rs2);
      end
`endif
    end
    return e;
  endfunction

  task automatic cycle(input logic rst, input logic wr, input logic [4:0] d,
                       input logic [31:0] wd, input logic iss, input logic [4:0] ird,
                       input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    commit();
    #1;
    reset = rst; wr_req = wr; rd = d; wr_data = wd;
    issue_req = iss; issue_rd = ird; rs1 = a1; rs2 = a2;
    q.push_back(predict());
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, a1, a2);
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  // Monitor: compares every presented output against the queued expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("ready", 64'(ready), 64'(e.r));
        check("rrs1",  64'(rrs1),  64'(e.a));
        check("rrs2",  64'(rrs2),  64'(e.b));
        check("pend1", 64'(pend1), 64'(e.p1));
        check("pend2", 64'(pend2), 64'(e.p2));
      end
    end
  end

  initial begin : stim
    int n;
    reset = 1'b0; wr_req = 1'b0; rd = '0; wr_data = '0;
    issue_req = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    reset_b = 1'b0; wr_req_b = 1'b0; rd_b = '0; wr_data_b = '0;
    issue_req_b = 1'b0; issue_rd_b = '0; rs1_b = '0; rs2_b = '0;
    m_ready = 1'b0; m_cnt = 0; m_pend = '0;

    // Reset for 3 cycles, sweep, then read every register
    repeat (3) cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd8);
    repeat (34) idle(5'd2, 5'd8);
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

    // Write then read x5
    cycle(1'b1, 1'b1, 5'd5, 32'hdeadbeef, 1'b0, 5'd0, 5'd5, 5'd5);
    idle(5'd5, 5'd5);

    // x0 protection on both the array and the scoreboard
    cycle(1'b1, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Scoreboard on x7
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd7);
    repeat (3) idle(5'd7, 5'd7);
    cycle(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd7);
    idle(5'd7, 5'd7);
    cycle(1'b1, 1'b1, 5'd7, 32'h78, 1'b1, 5'd7, 5'd7, 5'd7);
    idle(5'd7, 5'd7);
    cycle(1'b1, 1'b1, 5'd7, 32'h79, 1'b1, 5'd3, 5'd3, 5'd7);
    idle(5'd3, 5'd7);

    // Mid-sweep reset with a write attempt during the sweep
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, i == 4, 5'd3, 32'h5, i == 4, 5'd3, 5'd3, 5'd0);
    repeat (2) cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    for (int i = 0; i < 40; i++)
      cycle(1'b1, i == 4, 5'd3, 32'h5, 1'b0, 5'd0, 5'd3, 5'd8);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 399) != 0, $urandom_range(0, 1) == 1, pick(), $urandom,
            $urandom_range(0, 2) == 0, pick(), pick(), pick());
    repeat (2) idle(5'd0, 5'd0);
    @(negedge clk);
    #1;

    // Second configuration: 64-bit, 16 registers
    @(posedge clk);
    #1 reset_b = 1'b1;
    check("b_ready_at_release", 64'(ready_b), 64'(0));
    n = 0;
    while (!ready_b && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("b_ready_edges", 64'(n), 64'(16));
    rs1_b = 4'd2; rs2_b = 4'd8;
    #1;
    check("b_x2", rrs1_b, 64'h1_0000);
    check("b_x8", rrs2_b, 64'hff00);
    rs1_b = 4'd0; rs2_b = 4'd15;
    #1;
    check("b_x0", rrs1_b, 64'h0);
    check("b_x15", rrs2_b, 64'h0);
    @(posedge clk);
    #1;
    wr_req_b = 1'b1; rd_b = 4'd4; wr_data_b = 64'haaaa_5555_0000_1234;
    issue_req_b = 1'b1; issue_rd_b = 4'd9; rs1_b = 4'd4; rs2_b = 4'd9;
    @(posedge clk);
    #1;
    wr_req_b = 1'b0; issue_req_b = 1'b0;
    #1;
    check("b_x4", rrs1_b, 64'haaaa_5555_0000_1234);
    check("b_pend9", 64'(pend2_b), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
